// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle control sequencer: fetches one instruction over a req/ack
// handshake, then steps DECODE -> EXECUTE -> WRITEBACK. It gates the
// register-file write strobe, advances the PC, traps illegal opcodes, retries
// fetches that time out, honours halt at instruction boundaries and counts
// retired instructions.
module riscv_mc_sequencer #(
    parameter int unsigned          BUS_WIDTH     = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC      = '0,
    parameter int unsigned          FETCH_TIMEOUT = 16
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_HALT,
    output logic                 o_IMEM_REQ,
    output logic [BUS_WIDTH-1:0] o_IMEM_ADDR,
    input  logic                 i_IMEM_ACK,
    input  logic [BUS_WIDTH-1:0] i_IMEM_DATA,
    output logic [BUS_WIDTH-1:0] o_INST,
    input  logic                 i_DEC_REGWR,
    output logic                 o_REG_WE,
    output logic [BUS_WIDTH-1:0] o_PC,
    output logic                 o_ILLEGAL,
    output logic                 o_FETCH_ERR,
    output logic                 o_HALTED,
    output logic [31:0]          o_INSTRET
);

    // Counter only has to hold 0 .. FETCH_TIMEOUT-1 (FETCH_TIMEOUT >= 2).
    localparam int                   CNT_W    = $clog2(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [BUS_WIDTH-1:0] NOP_INST = BUS_WIDTH'(32'h0000_0013);
    localparam logic [BUS_WIDTH-1:0] PC_STEP  = BUS_WIDTH'(4);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_GAP,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    state_t               state_q,   state_d;
    logic [BUS_WIDTH-1:0] pc_q,      pc_d;
    logic [BUS_WIDTH-1:0] inst_q,    inst_d;
    logic [31:0]          instret_q, instret_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;

    logic imem_req;
    logic reg_we;
    logic illegal;
    logic fetch_err;
    logic halted;

    // Only R-type and I-type ALU operations are executed by this core.
    function automatic logic is_legal_op(input logic [6:0] opcode);
        return (opcode == 7'b0110011) || (opcode == 7'b0010011);
    endfunction

    // State register; reset parks the sequencer in HALT with a NOP loaded.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= S_HALT;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            instret_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and output decode; strobes are combinational so they fall
    // immediately when reset forces the state back to HALT.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        cnt_d     = cnt_q;
        imem_req  = 1'b0;
        reg_we    = 1'b0;
        illegal   = 1'b0;
        fetch_err = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_HALT: begin
                halted = 1'b1;
                if (!i_HALT) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                // An ack in the timeout cycle takes priority over the error.
                if (i_IMEM_ACK) begin
                    inst_d  = i_IMEM_DATA;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Drops the request for one cycle so a retry is a fresh request.
            S_GAP: begin
                state_d = S_FETCH;
            end

            S_DECODE: begin
                if (is_legal_op(inst_q[6:0])) begin
                    state_d = S_EXECUTE;
                end else begin
                    // Trap: skip the instruction without writing or retiring.
                    illegal = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = i_HALT ? S_HALT : S_FETCH;
                end
            end

            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end

            S_WRITEBACK: begin
                reg_we    = i_DEC_REGWR;
                pc_d      = pc_q + PC_STEP;
                instret_d = instret_q + 32'd1;
                state_d   = i_HALT ? S_HALT : S_FETCH;
            end

            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign o_IMEM_REQ  = imem_req;
    assign o_IMEM_ADDR = pc_q;
    assign o_INST      = inst_q;
    assign o_REG_WE    = reg_we;
    assign o_PC        = pc_q;
    assign o_ILLEGAL   = illegal;
    assign o_FETCH_ERR = fetch_err;
    assign o_HALTED    = halted;
    assign o_INSTRET   = instret_q;

endmodule

// File: doc/riscv_mc_sequencer.md
Name: riscv_mc_sequencer

Overview:
Multi-cycle control sequencer for the RISC-V core. It fetches each instruction over a req/ack instruction-memory handshake and holds it in an instruction register that feeds the combinational decoder. It then steps DECODE/EXECUTE/WRITEBACK, gates the register-file write strobe, and advances the PC. It also flags illegal opcodes, detects fetch timeouts, supports halt, and counts retired instructions.

Parameters:
BUS_WIDTH, 32, width of PC, instruction and data buses
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, FETCH cycles without ack before a fetch error (>=2)

Ports:
i_CLK  input  1  clock, all state on rising edge
i_RST  input  1  asynchronous active-high reset
i_HALT  input  1  halt request, sampled only at instruction boundaries
o_IMEM_REQ  output  1  fetch request, held until ack
o_IMEM_ADDR  output  BUS_WIDTH  fetch address, always equal to o_PC
i_IMEM_ACK  input  1  fetch acknowledge, sampled on rising edge while o_IMEM_REQ=1
i_IMEM_DATA  input  BUS_WIDTH  instruction word, valid in the ack cycle
o_INST  output  BUS_WIDTH  instruction register, drives the decoder
i_DEC_REGWR  input  1  register-write enable from the decoder for o_INST
o_REG_WE  output  1  gated register-file write strobe
o_PC  output  BUS_WIDTH  current program counter
o_ILLEGAL  output  1  1-cycle pulse when an unsupported opcode is decoded
o_FETCH_ERR  output  1  1-cycle pulse on fetch timeout
o_HALTED  output  1  high while in the HALT state
o_INSTRET  output  32  retired-instruction counter

Behaviour:
- Reset (async, immediate):
  - State=HALT, o_PC=RESET_PC, o_INST=32'h0000_0013 (NOP).
  - o_IMEM_REQ, o_REG_WE, o_ILLEGAL and o_FETCH_ERR all 0.
  - o_INSTRET=0, timeout counter=0, o_HALTED=1.
- Reset mid-operation aborts any transaction: o_IMEM_REQ drops asynchronously, no write, no PC update.
- States: HALT, FETCH, GAP, DECODE, EXECUTE, WRITEBACK.
- HALT: o_HALTED=1, no request. If i_HALT=0, go to FETCH next cycle; otherwise stay.
- FETCH:
  - o_IMEM_REQ=1, with o_IMEM_ADDR held stable.
  - On ack: latch i_IMEM_DATA into o_INST, clear the counter, go to DECODE.
  - With no ack: increment the counter. When the counter reaches FETCH_TIMEOUT-1, pulse o_FETCH_ERR, clear the counter and go to GAP.
  - If ack arrives in the timeout cycle, ack wins: no error, normal latch.
- GAP: one cycle with o_IMEM_REQ=0, then FETCH again at the same PC. Request must never stay high across a retry.
- DECODE: one cycle. Legal opcodes are o_INST[6:0] = 7'b0110011 (R-type ALU) and 7'b0010011 (I-type ALU).
  - Legal opcode: go to EXECUTE.
  - Illegal opcode: pulse o_ILLEGAL, o_PC<=o_PC+4, no write, no retire. Next state is HALT if i_HALT=1, else FETCH.
- EXECUTE: one cycle for the ALU/immediate path to settle. No outputs change.
- WRITEBACK: one cycle.
  - o_REG_WE=i_DEC_REGWR, combinational AND with the state decode.
  - o_PC<=o_PC+4, o_INSTRET<=o_INSTRET+1.
  - Next state is HALT if i_HALT=1, else FETCH.
- o_REG_WE is 0 in every state except WRITEBACK.
- Latency: with zero-wait ack, one instruction takes 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK). Each wait cycle adds 1.
- i_HALT is ignored mid-instruction; an in-flight instruction always completes or traps.
- PC arithmetic is modulo 2^BUS_WIDTH: 32'hFFFF_FFFC+4 wraps to 0. o_INSTRET wraps from 32'hFFFF_FFFF to 0.
- o_INST holds its value from ack until the next ack; it is not cleared on error or illegal.
- Ack while o_IMEM_REQ=0 is ignored.

Test Plan:
- Reset release with i_HALT=0; memory returns 32'h0020_81B3 (add x3,x1,x2) with immediate ack and i_DEC_REGWR=1 -> REQ at 0x0; o_REG_WE high exactly in the 4th cycle; o_PC=4; o_INSTRET=1.
- Ack delayed 3 cycles with data 32'h0050_8093 (addi) -> REQ held 4 cycles with stable address; write in cycle 7; o_PC=4.
- No ack with FETCH_TIMEOUT=16 -> o_FETCH_ERR pulse after 16 FETCH cycles, REQ low for 1 cycle, re-request at the same PC; an ack in the timeout cycle produces no error.
- Fetch 32'h0000_0063 (branch opcode) -> o_ILLEGAL pulse in DECODE, o_REG_WE never high, o_PC+=4, o_INSTRET unchanged.
- i_HALT raised during EXECUTE -> instruction retires, then HALT with o_HALTED=1 and no REQ. Drop i_HALT -> FETCH resumes at the next PC.
- Assert i_RST mid-FETCH with o_PC=0x40 -> REQ drops immediately, o_PC=RESET_PC, o_INST=32'h13, o_INSTRET=0. Also preload PC=0xFFFF_FFFC and retire -> o_PC=0.
